mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester round-robin arbiter in front of a single-port
//               synchronous-read RAM. Core (A) and host loader (B) each get
//               one-cycle grants. Reads return registered data with a
//               one-cycle rvalid pulse.
// Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              rvalid_a,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_RESP   = 2'd2;

    localparam logic c_SEL_A = 1'b0;
    localparam logic c_SEL_B = 1'b1;

    logic [1:0]        r_state;
    logic              r_sel;
    logic              r_last;
    logic              r_gnt_a;
    logic              r_gnt_b;
    logic              r_busy;
    logic              r_rvalid_a;
    logic              r_rvalid_b;
    logic [DATA_W-1:0] r_rdata_a;
    logic [DATA_W-1:0] r_rdata_b;
    logic [ADDR_W-1:0] r_resp_addr;

    logic              w_any_req;
    logic              w_winner;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_sel_we;

    // Winner of an IDLE arbitration: a lone request wins, a tie goes to the
    // requester that was not served last.
    assign w_any_req   = req_a | req_b;
    assign w_winner    = (req_a && req_b) ? ~r_last : req_b;

    // Selected requester's transaction fields; requesters hold them stable
    // through their grant cycle, so a direct mux is safe in ACCESS.
    assign w_sel_addr  = (r_sel == c_SEL_B) ? addr_b  : addr_a;
    assign w_sel_wdata = (r_sel == c_SEL_B) ? wdata_b : wdata_a;
    assign w_sel_we    = (r_sel == c_SEL_B) ? we_b    : we_a;

    // Arbitration FSM with registered grant, busy, rvalid and rdata outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_sel       <= c_SEL_A;
            r_last      <= c_SEL_B;
            r_gnt_a     <= 1'b0;
            r_gnt_b     <= 1'b0;
            r_busy      <= 1'b0;
            r_rvalid_a  <= 1'b0;
            r_rvalid_b  <= 1'b0;
            r_rdata_a   <= '0;
            r_rdata_b   <= '0;
            r_resp_addr <= '0;
        end else begin
            r_gnt_a    <= 1'b0;
            r_gnt_b    <= 1'b0;
            r_rvalid_a <= 1'b0;
            r_rvalid_b <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (en && w_any_req) begin
                        r_sel   <= w_winner;
                        r_last  <= w_winner;
                        r_gnt_a <= (w_winner == c_SEL_A);
                        r_gnt_b <= (w_winner == c_SEL_B);
                        r_busy  <= 1'b1;
                        r_state <= c_ACCESS;
                    end
                end
                c_ACCESS: begin
                    // The requester may change its address after the grant,
                    // so the read address is kept for the response cycle.
                    r_resp_addr <= w_sel_addr;
                    if (w_sel_we) begin
                        r_busy  <= 1'b0;
                        r_state <= c_IDLE;
                    end else begin
                        r_state <= c_RESP;
                    end
                end
                c_RESP: begin
                    if (r_sel == c_SEL_A) begin
                        r_rdata_a  <= mem_rdata;
                        r_rvalid_a <= 1'b1;
                    end else begin
                        r_rdata_b  <= mem_rdata;
                        r_rvalid_b <= 1'b1;
                    end
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // RAM port drive: selected requester in ACCESS, held address in RESP,
    // quiet otherwise.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        case (r_state)
            c_ACCESS: begin
                mem_addr  = w_sel_addr;
                mem_wdata = w_sel_wdata;
                mem_we    = w_sel_we;
            end
            c_RESP: begin
                mem_addr  = r_resp_addr;
            end
            default: begin
                mem_addr  = '0;
            end
        endcase
    end

    assign gnt_a    = r_gnt_a;
    assign gnt_b    = r_gnt_b;
    assign busy     = r_busy;
    assign rvalid_a = r_rvalid_a;
    assign rvalid_b = r_rvalid_b;
    assign rdata_a  = r_rdata_a;
    assign rdata_b  = r_rdata_b;

endmodule
`default_nettype wire
